hex_word_serializer: RTL and testbench

- Accepts a DATA_W-bit binary word over a valid/ready handshake and emits it as ASCII hex characters, one byte per handshake, most-significant nibble first.
- Optionally adds a "0x" prefix and a CR LF terminator.
- Sits between debug/telemetry sources (PID error, sensor distance) and the UART transmitter's byte input.
- Generalises the fixed 4-bit nibble converter to a parametrised, sequenced word formatter.

---
 rtl/hex_fmt_pkg.sv | 20 ++
 rtl/hex_nibble_to_ascii.sv | 18 +
 rtl/hex_word_serializer.sv | 117 +++++++++++
 tb/tb_hex_word_serializer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_fmt_pkg.sv
// Shared state encoding and ASCII constants for the hex word formatter.
package hex_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PFX0  = 3'd1,
    PFX1  = 3'd2,
    DIGIT = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_X  = 8'h78;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit value to ASCII hex digit converter.
module hex_nibble_to_ascii
  import hex_fmt_pkg::*;
#(
  parameter bit LOWERCASE = 1'b0
) (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_char_c
);

  localparam logic [7:0] ALPHA_BASE = LOWERCASE ? ASCII_LA : ASCII_UA;

  always_comb begin
    if (i_nibble < 4'd10) o_char_c = ASCII_0 + 8'(i_nibble);
    else                  o_char_c = ALPHA_BASE + 8'(i_nibble) - 8'd10;
  end

endmodule

// File: rtl/hex_word_serializer.sv
// Formats a binary word as a stream of ASCII hex characters, MS nibble first,
// with optional "0x" prefix and CR LF terminator, over valid/ready handshakes.
module hex_word_serializer
  import hex_fmt_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter bit          ADD_PREFIX = 1'b0,
  parameter bit          ADD_CRLF   = 1'b1,
  parameter bit          LOWERCASE  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              busy
);

  localparam int unsigned    NDIG     = DATA_W / 4;
  localparam int unsigned    CNT_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  if ((DATA_W % 4) != 0 || DATA_W < 4) begin : g_bad_width
    $error("hex_word_serializer: DATA_W must be a multiple of 4 and at least 4");
  end

  state_t              r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [DATA_W-1:0]   r_shadow, w_shadow_n;
  logic                r_in_ready, r_out_valid, r_busy;
  logic [7:0]          r_out_char, w_char_n, w_digit_char;
  logic [3:0]          w_nibble_n;
  logic                w_adv;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign busy      = r_busy;

  assign w_adv = r_out_valid && out_ready;

  // Next-state, counter and shadow-word update; stalls leave everything unchanged.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_shadow_n = r_shadow;
    unique case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_shadow_n = in_data;
          w_cnt_n    = CNT_LAST;
          w_state_n  = ADD_PREFIX ? PFX0 : DIGIT;
        end
      end
      PFX0: if (w_adv) w_state_n = PFX1;
      PFX1: begin
        if (w_adv) begin
          w_state_n = DIGIT;
          w_cnt_n   = CNT_LAST;
        end
      end
      DIGIT: begin
        if (w_adv) begin
          if (r_cnt == '0) w_state_n = ADD_CRLF ? CR : IDLE;
          else             w_cnt_n   = r_cnt - CNT_W'(1);
        end
      end
      CR:      if (w_adv) w_state_n = LF;
      LF:      if (w_adv) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  assign w_nibble_n = 4'(w_shadow_n >> {w_cnt_n, 2'b00});

  hex_nibble_to_ascii #(.LOWERCASE(LOWERCASE)) u_nib (
    .i_nibble (w_nibble_n),
    .o_char_c (w_digit_char)
  );

  // Character that the next state presents; registered so out_char is glitch-free.
  always_comb begin
    w_char_n = 8'h00;
    unique case (w_state_n)
      PFX0:    w_char_n = ASCII_0;
      PFX1:    w_char_n = ASCII_X;
      DIGIT:   w_char_n = w_digit_char;
      CR:      w_char_n = ASCII_CR;
      LF:      w_char_n = ASCII_LF;
      default: w_char_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_char  <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_shadow    <= w_shadow_n;
      r_in_ready  <= (w_state_n == IDLE);
      r_out_valid <= (w_state_n != IDLE);
      r_out_char  <= w_char_n;
      r_busy      <= (w_state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_hex_word_serializer.sv
// Bench for hex_word_serializer: three configurations, table vectors,
// hand-written corner sequences and random words against a string-based model.
module tb_hex_word_serializer;

  typedef logic [7:0] byte_q_t [$];

  typedef struct {
    logic [15:0] word;
    int          mode;
    logic [47:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] nib;
    logic [7:0] exp;
  } nvec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A: defaults (16-bit, CRLF, uppercase)
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_data;
  logic [7:0]  a_out_char;
  // B: 8-bit, prefix, lowercase
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [7:0] b_in_data;
  logic [7:0] b_out_char;
  // C: 4-bit, no CRLF
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [3:0] c_in_data;
  logic [7:0] c_out_char;

  hex_word_serializer u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_char(a_out_char), .busy(a_busy));

  hex_word_serializer #(.DATA_W(8), .ADD_PREFIX(1'b1), .ADD_CRLF(1'b1), .LOWERCASE(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_char(b_out_char), .busy(b_busy));

  hex_word_serializer #(.DATA_W(4), .ADD_PREFIX(1'b0), .ADD_CRLF(1'b0), .LOWERCASE(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_char(c_out_char), .busy(c_busy));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: prefix, digits looked up in a hex alphabet string, terminator.
  function automatic byte_q_t model(input logic [31:0] w, input int ndig,
                                    input bit pfx, input bit crlf, input bit lower);
    byte_q_t q;
    string   hexdig;
    int      n;
    hexdig = lower ? "0123456789abcdef" : "0123456789ABCDEF";
    if (pfx) begin q.push_back(8'h30); q.push_back(8'h78); end
    for (int i = ndig - 1; i >= 0; i--) begin
      n = int'((w >> (4 * i)) & 32'hF);
      q.push_back(hexdig[n]);
    end
    if (crlf) begin q.push_back(8'h0D); q.push_back(8'h0A); end
    return q;
  endfunction

  task automatic check_stream(input string name, input byte_q_t got, input byte_q_t exp);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_c%0d", name, i), got[i], exp[i]);
  endtask

  // Output monitors: record accepted characters; on A also check stall stability.
  byte_q_t    a_q, b_q, c_q;
  int         a_acc[$];
  logic       a_prev_stall = 1'b0;
  logic [7:0] a_prev_char  = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_prev_stall <= 1'b0;
    end else begin
      if (a_prev_stall) chk("a_hold", {a_out_valid, a_out_char}, {1'b1, a_prev_char});
      if (a_out_valid && a_out_ready) a_q.push_back(a_out_char);
      if (a_in_valid && a_in_ready) a_acc.push_back(cyc);
      if (b_out_valid && b_out_ready) b_q.push_back(b_out_char);
      if (c_out_valid && c_out_ready) c_q.push_back(c_out_char);
      a_prev_stall <= a_out_valid && !a_out_ready;
      a_prev_char  <= a_out_char;
    end
  end

  task automatic drive(input int sel, input bit v, input logic [15:0] d, input bit r);
    case (sel)
      0: begin a_in_valid = v; a_in_data = d;     a_out_ready = r; end
      1: begin b_in_valid = v; b_in_data = 8'(d); b_out_ready = r; end
      default: begin c_in_valid = v; c_in_data = 4'(d); c_out_ready = r; end
    endcase
  endtask

  // {in_ready, out_valid, busy, out_char}
  function automatic logic [10:0] obs(input int sel);
    case (sel)
      0:       return {a_in_ready, a_out_valid, a_busy, a_out_char};
      1:       return {b_in_ready, b_out_valid, b_busy, b_out_char};
      default: return {c_in_ready, c_out_valid, c_busy, c_out_char};
    endcase
  endfunction

  function automatic byte_q_t got_q(input int sel);
    case (sel)
      0:       return a_q;
      1:       return b_q;
      default: return c_q;
    endcase
  endfunction

  task automatic clr(input int sel);
    case (sel)
      0:       a_q.delete();
      1:       b_q.delete();
      default: c_q.delete();
    endcase
  endtask

  // mode 0: out_ready always high; 1: ready pattern 1,0,0,...; 2: random ready.
  task automatic send(input int sel, input string name, input logic [15:0] w,
                      input int mode, input byte_q_t exp);
    int          k;
    bit          ok;
    bit          r;
    logic [10:0] o;
    clr(sel);
    ok = 1'b0;
    drive(sel, 1'b1, w, 1'b1);
    for (k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      o  = obs(sel);
      ok = o[10];
      @(posedge clk); #1;
    end
    drive(sel, 1'b0, 16'($urandom), 1'b1);
    if (!ok) begin
      chk({name, "_accept_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (mode == 0) begin
      o = obs(sel);
      chk({name, "_first"}, {23'd0, o[9], o[7:0]}, {23'd0, 1'b1, exp[0]});
    end
    o = obs(sel);
    for (k = 0; k < 300 && o[8]; k++) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      drive(sel, 1'b0, 16'($urandom), r);
      @(posedge clk); #1;
      o = obs(sel);
    end
    drive(sel, 1'b0, 16'($urandom), 1'b1);
    if (mode == 0) chk({name, "_cycles"}, k, exp.size());
    chk({name, "_idle"}, {29'd0, o[8], o[9], o[10]}, 32'b001);
    check_stream(name, got_q(sel), exp);
  endtask

  vec_t    vecs[5];
  nvec_t   nvecs[16];
  byte_q_t e;
  int      k;
  bit      ok;
  logic [15:0] w;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{word: 16'hBEEF, mode: 0, exp: 48'h4245_4546_0D0A};
    vecs[1] = '{word: 16'h1234, mode: 1, exp: 48'h3132_3334_0D0A};
    vecs[2] = '{word: 16'h0000, mode: 2, exp: 48'h3030_3030_0D0A};
    vecs[3] = '{word: 16'hFFFF, mode: 0, exp: 48'h4646_4646_0D0A};
    vecs[4] = '{word: 16'h7A5C, mode: 1, exp: 48'h3741_3543_0D0A};
    for (int i = 0; i < 16; i++) begin
      nvecs[i].nib = 4'(i);
      nvecs[i].exp = (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10);
    end

    rst_n = 1'b0;
    drive(0, 1'b0, 16'h0, 1'b0);
    drive(1, 1'b0, 16'h0, 1'b0);
    drive(2, 1'b0, 16'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", {21'd0, obs(0)}, {21'd0, 3'b000, 8'h00});
    chk("rst_b", {21'd0, obs(1)}, {21'd0, 3'b000, 8'h00});
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy", {29'd0, a_in_ready, b_in_ready, c_in_ready}, 32'b111);

    // Table vectors on A
    for (int i = 0; i < 5; i++) begin
      e = {};
      for (int j = 0; j < 6; j++) e.push_back(vecs[i].exp[47 - 8*j -: 8]);
      send(0, $sformatf("vec%0d", i), vecs[i].word, vecs[i].mode, e);
    end

    // Back-to-back words with in_valid held, in_data disturbed mid-word
    a_q.delete();
    a_acc.delete();
    drive(0, 1'b1, 16'h0000, 1'b1);
    ok = 1'b0;
    for (k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = a_in_ready; @(posedge clk); #1;
    end
    a_in_data = 16'hAAAA;
    repeat (3) @(posedge clk);
    #1 a_in_data = 16'hFFFF;
    for (k = 0; k < 50 && a_acc.size() < 2; k++) begin
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    chk("b2b_accepts", a_acc.size(), 2);
    if (a_acc.size() == 2) chk("b2b_gap", a_acc[1] - a_acc[0], 7);
    for (k = 0; k < 50 && a_busy; k++) begin
      @(posedge clk); #1;
    end
    e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    check_stream("b2b", a_q, e);

    // Mid-frame reset after the second digit of ABCD
    a_q.delete();
    drive(0, 1'b1, 16'hABCD, 1'b1);
    ok = 1'b0;
    for (k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = a_in_ready; @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", {21'd0, obs(0)}, {21'd0, 3'b000, 8'h00});
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release", {30'd0, a_in_ready, a_out_valid}, 32'b10);
    check_stream("midrst", a_q, '{8'h41, 8'h42});
    send(0, "after_rst", 16'h0009, 0, '{8'h30, 8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A});

    // B: prefix + lowercase, 8-bit
    send(1, "b_3c", 16'h003C, 0, '{8'h30, 8'h78, 8'h33, 8'h63, 8'h0D, 8'h0A});

    // C: single-nibble sweep, one character per word
    for (int i = 0; i < 16; i++) begin
      e = '{nvecs[i].exp};
      send(2, $sformatf("nib%0d", i), 16'(nvecs[i].nib), 0, e);
    end

    // Random words with random backpressure
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      send(0, $sformatf("rand_a%0d", i), w, 2, model(32'(w), 4, 1'b0, 1'b1, 1'b0));
    end
    for (int i = 0; i < 10; i++) begin
      w = 16'($urandom_range(0, 255));
      send(1, $sformatf("rand_b%0d", i), w, 2, model(32'(w), 2, 1'b1, 1'b1, 1'b1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
